// File: rtl/regbank_client.sv
// regbank_client: requester-side controller for the 16-entry register bank.
// Fetches two operands per request through a one-deep output register and
// merges ALU/load writebacks into the bank's single write port via a 2-entry
// write queue whose contents are forwarded to operand reads.
module regbank_client #(
    parameter int REG_WIDTH = 32,
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [ADDR_W-1:0]    op_ra,
    input  logic [ADDR_W-1:0]    op_rb,
    output logic                 opd_valid,
    input  logic                 opd_ready,
    output logic [REG_WIDTH-1:0] opd_a,
    output logic [REG_WIDTH-1:0] opd_b,
    input  logic                 alu_wvalid,
    input  logic [ADDR_W-1:0]    alu_waddr,
    input  logic [REG_WIDTH-1:0] alu_wdata,
    input  logic                 mem_wvalid,
    output logic                 mem_wready,
    input  logic [ADDR_W-1:0]    mem_waddr,
    input  logic [REG_WIDTH-1:0] mem_wdata,
    output logic [ADDR_W-1:0]    rb_raddr1,
    output logic [ADDR_W-1:0]    rb_raddr2,
    input  logic [REG_WIDTH-1:0] rb_rdata1,
    input  logic [REG_WIDTH-1:0] rb_rdata2,
    output logic                 rb_we,
    output logic [ADDR_W-1:0]    rb_waddr,
    output logic [REG_WIDTH-1:0] rb_wdata,
    output logic                 wb_idle
);

    // Write queue: index 0 is the head (oldest), index 1 the younger entry.
    logic [ADDR_W-1:0]    addr_q [2];
    logic [ADDR_W-1:0]    addr_d [2];
    logic [REG_WIDTH-1:0] data_q [2];
    logic [REG_WIDTH-1:0] data_d [2];
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic [1:0]           slot;
    logic                 mem_push;

    logic                 opd_valid_q;
    logic [REG_WIDTH-1:0] opd_a_q;
    logic [REG_WIDTH-1:0] opd_b_q;
    logic [REG_WIDTH-1:0] fwd_a;
    logic [REG_WIDTH-1:0] fwd_b;
    logic                 op_accept;

    assign op_ready   = !opd_valid_q || opd_ready;
    assign op_accept  = op_valid && op_ready;
    assign opd_valid  = opd_valid_q;
    assign opd_a      = opd_a_q;
    assign opd_b      = opd_b_q;

    assign rb_raddr1  = op_ra;
    assign rb_raddr2  = op_rb;
    assign rb_we      = (count_q != 2'd0);
    assign rb_waddr   = rb_we ? addr_q[0] : '0;
    assign rb_wdata   = rb_we ? data_q[0] : '0;
    assign wb_idle    = (count_q == 2'd0);

    // After this cycle's pop only a full queue leaves one slot occupied, so
    // that is the only case where a same-cycle ALU push can crowd out mem.
    assign mem_wready = (count_q < 2'd2) || !alu_wvalid;
    assign mem_push   = mem_wvalid && mem_wready;

    // Queue next state: pop head, keep survivor, then append ALU before mem.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        slot    = 2'd0;
        if (count_q == 2'd2) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_q[1];
            slot      = 2'd1;
        end
        if (alu_wvalid) begin
            addr_d[slot[0]] = alu_waddr;
            data_d[slot[0]] = alu_wdata;
            slot            = slot + 2'd1;
        end
        if (mem_push) begin
            addr_d[slot[0]] = mem_waddr;
            data_d[slot[0]] = mem_wdata;
            slot            = slot + 2'd1;
        end
        count_d = slot;
    end

    // Forwarding: youngest matching queued entry wins, bank data otherwise.
    // The head still counts while it commits, covering write-during-read.
    always_comb begin
        fwd_a = rb_rdata1;
        fwd_b = rb_rdata2;
        if (count_q != 2'd0 && addr_q[0] == op_ra) fwd_a = data_q[0];
        if (count_q == 2'd2 && addr_q[1] == op_ra) fwd_a = data_q[1];
        if (count_q != 2'd0 && addr_q[0] == op_rb) fwd_b = data_q[0];
        if (count_q == 2'd2 && addr_q[1] == op_rb) fwd_b = data_q[1];
    end

    // Write queue storage; reset discards any uncommitted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Operand register: snapshot on accept, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opd_valid_q <= 1'b0;
            opd_a_q     <= '0;
            opd_b_q     <= '0;
        end else if (op_accept) begin
            opd_valid_q <= 1'b1;
            opd_a_q     <= fwd_a;
            opd_b_q     <= fwd_b;
        end else if (opd_ready) begin
            opd_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regbank_client.sv
// Directed bench for regbank_client with a behavioural register bank.
module tb_regbank_client;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready, opd_valid, opd_ready;
    logic [3:0]  op_ra, op_rb;
    logic [31:0] opd_a, opd_b;
    logic        alu_wvalid, mem_wvalid, mem_wready;
    logic [3:0]  alu_waddr, mem_waddr;
    logic [31:0] alu_wdata, mem_wdata;
    logic [3:0]  rb_raddr1, rb_raddr2, rb_waddr;
    logic [31:0] rb_rdata1, rb_rdata2, rb_wdata;
    logic        rb_we, wb_idle;

    logic [31:0] bank [16];
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [31:0] pl_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regbank_client dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_ra(op_ra), .op_rb(op_rb),
        .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
        .alu_wvalid(alu_wvalid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rb_raddr1(rb_raddr1), .rb_raddr2(rb_raddr2),
        .rb_rdata1(rb_rdata1), .rb_rdata2(rb_rdata2),
        .rb_we(rb_we), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
        .wb_idle(wb_idle)
    );

    // Bank: combinational read, commit on rising edge; preload port for setup.
    assign rb_rdata1 = bank[rb_raddr1];
    assign rb_rdata2 = bank[rb_raddr2];
    always @(posedge clk) begin
        if (pl_en) bank[pl_addr] <= pl_data;
        else if (rb_we) bank[rb_waddr] <= rb_wdata;
    end

    function automatic logic [31:0] pv(input int i);
        if (i == 3) return 32'h11;
        if (i == 7) return 32'h22;
        return 32'h1000 + i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        op_valid = 0; op_ra = 0; op_rb = 0; opd_ready = 1;
        alu_wvalid = 0; alu_waddr = 0; alu_wdata = 0;
        mem_wvalid = 0; mem_waddr = 0; mem_wdata = 0;
        pl_en = 0; pl_addr = 0; pl_data = 0;
        #1;
        // preload bank while in reset
        for (int i = 0; i < 16; i++) begin
            pl_en = 1; pl_addr = 4'(i); pl_data = pv(i);
            tick();
        end
        pl_en = 0;
        settle();
        chk("rst_opd_valid", 32'(opd_valid), 32'd0);
        chk("rst_opd_a", opd_a, 32'd0);
        chk("rst_opd_b", opd_b, 32'd0);
        chk("rst_rb_we", 32'(rb_we), 32'd0);
        chk("rst_wb_idle", 32'(wb_idle), 32'd1);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_mem_wready", 32'(mem_wready), 32'd1);
        chk("rst_rb_waddr", 32'(rb_waddr), 32'd0);
        chk("rst_rb_wdata", rb_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Plain fetch R3/R7
        op_valid = 1; op_ra = 3; op_rb = 7;
        settle();
        chk("t1_op_ready", 32'(op_ready), 32'd1);
        chk("t1_rb_raddr1", 32'(rb_raddr1), 32'd3);
        chk("t1_rb_we", 32'(rb_we), 32'd0);
        tick();
        op_valid = 0;
        settle();
        chk("t1_opd_valid", 32'(opd_valid), 32'd1);
        chk("t1_opd_a", opd_a, 32'h11);
        chk("t1_opd_b", opd_b, 32'h22);
        chk("t1_rb_we2", 32'(rb_we), 32'd0);
        tick();
        chk("t1_opd_clear", 32'(opd_valid), 32'd0);

        // ALU push R5, forwarded on next cycle while committing
        alu_wvalid = 1; alu_waddr = 5; alu_wdata = 32'hA5;
        tick();
        alu_wvalid = 0;
        op_valid = 1; op_ra = 5; op_rb = 3;
        settle();
        chk("t2_rb_we", 32'(rb_we), 32'd1);
        chk("t2_rb_waddr", 32'(rb_waddr), 32'd5);
        chk("t2_rb_wdata", rb_wdata, 32'hA5);
        chk("t2_wb_idle", 32'(wb_idle), 32'd0);
        tick();
        op_valid = 0;
        settle();
        chk("t2_opd_a", opd_a, 32'hA5);
        chk("t2_opd_b", opd_b, 32'h11);
        chk("t2_bank5", bank[5], 32'hA5);
        chk("t2_wb_idle2", 32'(wb_idle), 32'd1);

        // Same-cycle ALU and mem to R2 from empty
        alu_wvalid = 1; alu_waddr = 2; alu_wdata = 32'h1;
        mem_wvalid = 1; mem_waddr = 2; mem_wdata = 32'h2;
        settle();
        chk("t3_mem_wready", 32'(mem_wready), 32'd1);
        tick();
        alu_wvalid = 0; mem_wvalid = 0;
        op_valid = 1; op_ra = 2; op_rb = 4;
        settle();
        chk("t3_rb_waddr", 32'(rb_waddr), 32'd2);
        chk("t3_rb_wdata0", rb_wdata, 32'h1);
        tick();
        op_valid = 0;
        settle();
        chk("t3_opd_a_young", opd_a, 32'h2);
        chk("t3_opd_b", opd_b, 32'h1004);
        chk("t3_bank2_first", bank[2], 32'h1);
        chk("t3_rb_wdata1", rb_wdata, 32'h2);
        tick();
        chk("t3_bank2_final", bank[2], 32'h2);
        chk("t3_wb_idle", 32'(wb_idle), 32'd1);
        chk("t3_rb_we", 32'(rb_we), 32'd0);

        // Full queue with both writers: mem backpressured
        alu_wvalid = 1; alu_waddr = 8;  alu_wdata = 32'h80;
        mem_wvalid = 1; mem_waddr = 9;  mem_wdata = 32'h90;
        tick();
        alu_waddr = 10; alu_wdata = 32'hA0;
        mem_waddr = 11; mem_wdata = 32'hB0;
        settle();
        chk("t4_mem_wready_full", 32'(mem_wready), 32'd0);
        tick();
        alu_wvalid = 0;
        op_valid = 1; op_ra = 9; op_rb = 10;
        settle();
        chk("t4_mem_wready_noalu", 32'(mem_wready), 32'd1);
        chk("t4_head_addr", 32'(rb_waddr), 32'd9);
        tick();
        mem_wvalid = 0; op_valid = 0;
        settle();
        chk("t4_fwd_head", opd_a, 32'h90);
        chk("t4_fwd_young", opd_b, 32'hA0);
        chk("t4_head_addr2", 32'(rb_waddr), 32'd10);
        chk("t4_bank8", bank[8], 32'h80);
        chk("t4_bank9", bank[9], 32'h90);
        tick();
        chk("t4_head_addr3", 32'(rb_waddr), 32'd11);
        chk("t4_head_data3", rb_wdata, 32'hB0);
        tick();
        chk("t4_bank10", bank[10], 32'hA0);
        chk("t4_bank11", bank[11], 32'hB0);
        chk("t4_wb_idle", 32'(wb_idle), 32'd1);

        // Backpressure on operand output
        opd_ready = 0;
        op_valid = 1; op_ra = 12; op_rb = 13;
        tick();
        op_ra = 0; op_rb = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                alu_wvalid = 1; alu_waddr = 12; alu_wdata = 32'hCC;
            end else begin
                alu_wvalid = 0;
            end
            settle();
            chk($sformatf("t5_op_ready_%0d", k), 32'(op_ready), 32'd0);
            chk($sformatf("t5_opd_valid_%0d", k), 32'(opd_valid), 32'd1);
            chk($sformatf("t5_opd_a_%0d", k), opd_a, 32'h100C);
            chk($sformatf("t5_opd_b_%0d", k), opd_b, 32'h100D);
            tick();
        end
        alu_wvalid = 0;
        opd_ready = 1;
        settle();
        chk("t5_op_ready_rel", 32'(op_ready), 32'd1);
        chk("t5_bank12", bank[12], 32'hCC);
        tick();
        op_valid = 0;
        settle();
        chk("t5_next_a", opd_a, 32'h1000);
        chk("t5_next_b", opd_b, 32'h1001);
        tick();
        chk("t5_drain", 32'(opd_valid), 32'd0);

        // Reset while queue full discards pending writes
        alu_wvalid = 1; alu_waddr = 14; alu_wdata = 32'hEE;
        mem_wvalid = 1; mem_waddr = 15; mem_wdata = 32'hFF;
        tick();
        alu_wvalid = 0; mem_wvalid = 0;
        settle();
        chk("t6_wb_busy", 32'(wb_idle), 32'd0);
        rst_n = 1'b0;
        settle();
        chk("t6_rst_idle", 32'(wb_idle), 32'd1);
        chk("t6_rst_we", 32'(rb_we), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_wb_idle", 32'(wb_idle), 32'd1);
        chk("t6_rb_we", 32'(rb_we), 32'd0);
        chk("t6_bank14", bank[14], 32'h100E);
        chk("t6_bank15", bank[15], 32'h100F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regbank_client.md
# regbank_client

Requester-side controller for the processor's 16-entry general-purpose register bank. It fetches two source operands per accepted request, with one-cycle registered latency and output backpressure. It merges writebacks from the ALU and the load unit into the bank's single write port through a 2-entry write queue, and forwards queued-but-uncommitted values to operand reads. It sits between decode/issue and execute, driving the bank's read and write ports.

## Interface
- REG_WIDTH, 32: register data width.
- REG_COUNT, 16: number of registers (R0–R15); R0 has no special behaviour.
- ADDR_W, $clog2(REG_COUNT): register address width.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operand fetch request.
- op_ready  out  1  request accepted when op_valid && op_ready.
- op_ra, op_rb  in  ADDR_W  source register indices.
- opd_valid  out  1  operands available.
- opd_ready  in  1  consumer takes operands when opd_valid && opd_ready.
- opd_a, opd_b  out  REG_WIDTH  operand values for op_ra and op_rb.
- alu_wvalid  in  1  ALU writeback; always accepted, so there is no ready signal.
- alu_waddr  in  ADDR_W  ALU destination register.
- alu_wdata  in  REG_WIDTH  ALU result.
- mem_wvalid  in  1  load writeback request.
- mem_wready  out  1  load writeback accepted when mem_wvalid && mem_wready.
- mem_waddr  in  ADDR_W  load destination register.
- mem_wdata  in  REG_WIDTH  load data.
- rb_raddr1, rb_raddr2  out  ADDR_W  bank read addresses; driven from op_ra and op_rb.
- rb_rdata1, rb_rdata2  in  REG_WIDTH  bank read data; combinational in the bank.
- rb_we  out  1  bank write enable; the bank commits on the clk rising edge.
- rb_waddr  out  ADDR_W  bank write address.
- rb_wdata  out  REG_WIDTH  bank write data.
- wb_idle  out  1  write queue empty; used by the pipeline for drain/flush.

## Operation
- Operand stage:
  - op_ready = !opd_valid || opd_ready.
  - On acceptance, opd_a and opd_b are registered from the forwarded read values; opd_valid is then set.
  - If opd_valid && !opd_ready, opd_a, opd_b and opd_valid hold.
  - opd_valid clears on a take with no new acceptance.
  - Operands are a snapshot taken at acceptance; later writes do not update held operands.
- Write queue (WQ):
  - 2-entry FIFO of {addr, data} with a 2-bit count.
  - Head is the oldest entry.
  - rb_we = (count != 0); rb_waddr and rb_wdata come combinationally from the head.
  - The head pops at every clock edge while count != 0, giving one commit per cycle.
- Push order within one cycle:
  - Existing entries are older than any new pushes.
  - An ALU entry pushed in a cycle is older than a mem entry pushed in the same cycle.
- Space rule:
  - Free slots after this cycle's pop: count 0 → 2, count 1 → 2, count 2 → 1.
  - The ALU push always fits.
  - mem_wready = (count < 2) || !alu_wvalid.
- Forwarding, per read port independently:
  - The read value is the youngest WQ entry whose addr matches the read index.
  - If no entry matches, the read value is rb_rdata.
  - The head entry being committed this cycle counts as a match, covering write-during-read on the same edge.
  - Same-cycle incoming pushes (alu_w*, mem_w*) are NOT forwarded. The issuing pipeline guarantees one cycle of separation.
- Same-address entries:
  - Two entries with the same address commit in queue order, so the younger value wins.
  - Forwarding returns the younger value.

## Timing
- Reset values:
  - opd_valid = 0, opd_a = 0, opd_b = 0.
  - WQ count = 0, so rb_we = 0 and wb_idle = 1.
  - op_ready = 1; mem_wready = 1.
  - rb_waddr and rb_wdata read 0 during reset.
- Reset asserted mid-operation: the queue is cleared and uncommitted writes are discarded; held operands are lost.
- Operand latency: request accepted at edge N → opd_valid high after edge N, with values reflecting WQ and bank state in the cycle before edge N.
- Write latency: a push at edge N makes the entry visible to forwarding in cycle N+1.
  - An entry pushed into an empty queue commits at edge N+1.
  - Each older entry ahead of it adds one cycle.
- Throughput: one operand fetch per cycle when opd_ready = 1; one bank commit per cycle.

## Test plan
- Reset, then fetch R3/R7 with the bank preloaded R3=0x11, R7=0x22 → opd_valid one cycle later, opd_a=0x11, opd_b=0x22; rb_we=0 throughout.
- ALU push R5=0xA5 at edge N, fetch R5 in cycle N+1 → forwarded opd_a=0xA5 while rb_we=1, rb_waddr=5; bank holds R5=0xA5 after edge N+1.
- Same-cycle alu R2=0x1 and mem R2=0x2 from empty → both accepted; a fetch of R2 on the next cycle returns 0x2; bank commits R2=0x1, then R2=0x2, then wb_idle=1.
- count=2 with alu_wvalid and mem_wvalid both high → mem_wready=0; the ALU entry is queued; mem is accepted on the next cycle, when count ≤ 1 or alu_wvalid is low.
- opd_ready held low for 3 cycles with op_valid high → op_ready=0; opd_a and opd_b stable; a write to the same register during the stall does not change the held operands.
- rst_n asserted while count=2 → after release, wb_idle=1, rb_we=0, and the bank contents for the two pending addresses are unchanged.
